// File: rtl/id_ex_pipe_stage.sv
// Decode-to-execute pipeline register with valid bit, stall/flush, load-use
// hazard detection with bubble insertion and a saturating bubble counter.
module id_ex_pipe_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int ALUCTL_W = 5,
  parameter int CNT_W    = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Stall,
  input  logic                Flush,
  input  logic                CountClear,
  input  logic                ValidIn,
  input  logic [REG_W-1:0]    RSDecode,
  input  logic [REG_W-1:0]    RTDecode,
  input  logic                RegWrite,
  input  logic                ALUSrc,
  input  logic                MemToReg,
  input  logic [1:0]          MemWrite,
  input  logic [1:0]          MemRead,
  input  logic [ALUCTL_W-1:0] ALUControl,
  input  logic [DATA_W-1:0]   ReadData1,
  input  logic [DATA_W-1:0]   ReadData2,
  input  logic [DATA_W-1:0]   SignExt,
  input  logic [REG_W-1:0]    DestReg,
  output logic                ValidOut,
  output logic [REG_W-1:0]    RSExecute,
  output logic [REG_W-1:0]    RTExecute,
  output logic [REG_W-1:0]    DestRegOut,
  output logic                RegWriteOut,
  output logic                ALUSrcOut,
  output logic                MemToRegOut,
  output logic [1:0]          MemWriteOut,
  output logic [1:0]          MemReadOut,
  output logic [ALUCTL_W-1:0] ALUControlOut,
  output logic [DATA_W-1:0]   ReadData1Out,
  output logic [DATA_W-1:0]   ReadData2Out,
  output logic [DATA_W-1:0]   SignExtOut,
  output logic                LoadUseStall,
  output logic [CNT_W-1:0]    BubbleCount
);

  logic                valid_q, valid_d;
  logic [REG_W-1:0]    rs_q, rs_d, rt_q, rt_d, dest_q, dest_d;
  logic                reg_write_q, reg_write_d;
  logic                alu_src_q, alu_src_d;
  logic                mem_to_reg_q, mem_to_reg_d;
  logic [1:0]          mem_write_q, mem_write_d;
  logic [1:0]          mem_read_q, mem_read_d;
  logic [ALUCTL_W-1:0] alu_ctl_q, alu_ctl_d;
  logic [DATA_W-1:0]   rd1_q, rd1_d, rd2_q, rd2_d, sext_q, sext_d;
  logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;

  logic load_use;
  logic insert_bubble;

  // RT is compared even for I-type instructions; a false hazard only costs a cycle.
  assign load_use = valid_q && (mem_read_q != 2'b00) && reg_write_q &&
                    (dest_q != '0) && ValidIn &&
                    ((dest_q == RSDecode) || (dest_q == RTDecode));

  assign insert_bubble = Flush || (!Stall && load_use);

  always_comb begin
    valid_d      = valid_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    dest_d       = dest_q;
    reg_write_d  = reg_write_q;
    alu_src_d    = alu_src_q;
    mem_to_reg_d = mem_to_reg_q;
    mem_write_d  = mem_write_q;
    mem_read_d   = mem_read_q;
    alu_ctl_d    = alu_ctl_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    sext_d       = sext_q;

    if (insert_bubble) begin
      valid_d      = 1'b0;
      rs_d         = '0;
      rt_d         = '0;
      dest_d       = '0;
      reg_write_d  = 1'b0;
      alu_src_d    = 1'b0;
      mem_to_reg_d = 1'b0;
      mem_write_d  = 2'b00;
      mem_read_d   = 2'b00;
      alu_ctl_d    = '0;
      rd1_d        = '0;
      rd2_d        = '0;
      sext_d       = '0;
    end else if (!Stall) begin
      valid_d      = ValidIn;
      rs_d         = RSDecode;
      rt_d         = RTDecode;
      dest_d       = DestReg;
      reg_write_d  = RegWrite;
      alu_src_d    = ALUSrc;
      mem_to_reg_d = MemToReg;
      mem_write_d  = MemWrite;
      mem_read_d   = MemRead;
      alu_ctl_d    = ALUControl;
      rd1_d        = ReadData1;
      rd2_d        = ReadData2;
      sext_d       = SignExt;
    end
  end

  // Clear wins over an increment on the same edge; the counter never wraps.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (CountClear) begin
      bubble_cnt_d = '0;
    end else if (insert_bubble && (bubble_cnt_q != '1)) begin
      bubble_cnt_d = bubble_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      valid_q      <= 1'b0;
      rs_q         <= '0;
      rt_q         <= '0;
      dest_q       <= '0;
      reg_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 2'b00;
      mem_read_q   <= 2'b00;
      alu_ctl_q    <= '0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      sext_q       <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      dest_q       <= dest_d;
      reg_write_q  <= reg_write_d;
      alu_src_q    <= alu_src_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      mem_read_q   <= mem_read_d;
      alu_ctl_q    <= alu_ctl_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      sext_q       <= sext_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ValidOut      = valid_q;
  assign RSExecute     = rs_q;
  assign RTExecute     = rt_q;
  assign DestRegOut    = dest_q;
  assign RegWriteOut   = reg_write_q;
  assign ALUSrcOut     = alu_src_q;
  assign MemToRegOut   = mem_to_reg_q;
  assign MemWriteOut   = mem_write_q;
  assign MemReadOut    = mem_read_q;
  assign ALUControlOut = alu_ctl_q;
  assign ReadData1Out  = rd1_q;
  assign ReadData2Out  = rd2_q;
  assign SignExtOut    = sext_q;
  assign LoadUseStall  = load_use;
  assign BubbleCount   = bubble_cnt_q;

endmodule
